// File: rtl/hazard_scheduler_if.sv
// Pipeline hazard bundle between the stage datapath and the hazard scheduler.
// The datapath (master) supplies stage register fields; the scheduler (slave) returns control.
interface hazard_scheduler_if;
  logic [4:0] rsD, rtD;
  logic       branchD, pcSrcD, mdUseD;
  logic [4:0] rsE, rtE, writeRegE;
  logic       regWriteE, memToRegE, mdStartE;
  logic [4:0] writeRegM;
  logic       regWriteM, memToRegM, memReqM, memAckM;
  logic [4:0] writeRegW;
  logic       regWriteW;
  logic       stallF, stallD, stallE, stallM;
  logic       flushD, clearE;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD;
  logic       mdBusy, memErr;

  modport master (
    output rsD, rtD, branchD, pcSrcD, mdUseD,
    output rsE, rtE, writeRegE, regWriteE, memToRegE, mdStartE,
    output writeRegM, regWriteM, memToRegM, memReqM, memAckM,
    output writeRegW, regWriteW,
    input  stallF, stallD, stallE, stallM, flushD, clearE,
    input  forwardAE, forwardBE, forwardAD, forwardBD, mdBusy, memErr
  );

  modport slave (
    input  rsD, rtD, branchD, pcSrcD, mdUseD,
    input  rsE, rtE, writeRegE, regWriteE, memToRegE, mdStartE,
    input  writeRegM, regWriteM, memToRegM, memReqM, memAckM,
    input  writeRegW, regWriteW,
    output stallF, stallD, stallE, stallM, flushD, clearE,
    output forwardAE, forwardBE, forwardAD, forwardBD, mdBusy, memErr
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Hazard/stall scheduler for the 5-stage pipeline: forwarding selects, load-use and branch
// stalls, a data-memory wait FSM with timeout, and a multi-cycle MUL/DIV occupancy counter.
module hazard_scheduler #(
  parameter int MEM_TIMEOUT = 255,
  parameter int MD_LATENCY  = 4
) (
  input logic          clk,
  input logic          reset,
  hazard_scheduler_if.slave hz
);

  localparam logic [7:0] TIMEOUT_L = MEM_TIMEOUT[7:0];
  localparam int         MW        = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MW-1:0] MD_LOAD = MW'(MD_LATENCY - 1);

  typedef enum logic {IDLE, WAIT} mem_state_t;

  function automatic logic match(input logic [4:0] x, input logic [4:0] y);
    return (x == y) && (x != 5'd0);
  endfunction

  mem_state_t    state_reg;
  logic [7:0]    tcnt_reg;
  logic          mem_err_reg;
  logic [MW-1:0] mcnt_reg;

  logic [1:0][4:0] src_e, src_d;
  logic [1:0][1:0] fwd_e;
  logic [1:0]      fwd_d;
  logic            lw_stall, br_stall, md_stall, data_stall, mem_stall, at_limit, md_busy;

  assign src_e[0] = hz.rsE;
  assign src_e[1] = hz.rtE;
  assign src_d[0] = hz.rsD;
  assign src_d[1] = hz.rtD;

  // Operand A and B share identical forwarding rules; M result wins over W result.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_e[gi] = (hz.regWriteM && match(hz.writeRegM, src_e[gi])) ? 2'b10 :
                         (hz.regWriteW && match(hz.writeRegW, src_e[gi])) ? 2'b01 : 2'b00;
      assign fwd_d[gi] = hz.regWriteM && match(hz.writeRegM, src_d[gi]);
    end
  endgenerate

  assign lw_stall = hz.memToRegE && hz.regWriteE &&
                    (match(hz.writeRegE, hz.rsD) || match(hz.writeRegE, hz.rtD));
  assign br_stall = hz.branchD &&
                    ((hz.regWriteE && (match(hz.writeRegE, hz.rsD) || match(hz.writeRegE, hz.rtD))) ||
                     (hz.memToRegM && (match(hz.writeRegM, hz.rsD) || match(hz.writeRegM, hz.rtD))));
  assign md_busy    = (mcnt_reg != '0);
  assign md_stall   = md_busy && hz.mdUseD;
  assign data_stall = lw_stall || br_stall || md_stall;

  // The timeout cycle itself releases the pipeline; memErr follows one cycle later.
  assign at_limit  = (tcnt_reg == TIMEOUT_L);
  assign mem_stall = (state_reg == IDLE) ? (hz.memReqM && !hz.memAckM)
                                         : (!hz.memAckM && !at_limit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      tcnt_reg    <= 8'd0;
      mem_err_reg <= 1'b0;
    end else begin
      mem_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (hz.memReqM && !hz.memAckM) begin
            state_reg <= WAIT;
            tcnt_reg  <= 8'd1;
          end
        end
        WAIT: begin
          if (hz.memAckM) begin
            state_reg <= IDLE;
          end else if (at_limit) begin
            state_reg   <= IDLE;
            tcnt_reg    <= 8'd0;
            mem_err_reg <= 1'b1;
          end else begin
            tcnt_reg <= tcnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Counter keeps draining during memory stalls; a new start while busy is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcnt_reg <= '0;
    end else if (hz.mdStartE && !md_busy) begin
      mcnt_reg <= MD_LOAD;
    end else if (md_busy) begin
      mcnt_reg <= mcnt_reg - 1'b1;
    end
  end

  always_comb begin
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.stallM    = 1'b0;
    hz.clearE    = 1'b0;
    hz.flushD    = 1'b0;
    hz.forwardAE = 2'b00;
    hz.forwardBE = 2'b00;
    hz.forwardAD = 1'b0;
    hz.forwardBD = 1'b0;
    if (!reset) begin
      hz.clearE = 1'b1;
      hz.flushD = 1'b1;
    end else begin
      hz.forwardAE = fwd_e[0];
      hz.forwardBE = fwd_e[1];
      hz.forwardAD = fwd_d[0];
      hz.forwardBD = fwd_d[1];
      if (mem_stall) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.stallM = 1'b1;
      end else if (data_stall) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.clearE = 1'b1;
      end else begin
        hz.flushD = hz.pcSrcD;
      end
    end
  end

  assign hz.mdBusy = md_busy;
  assign hz.memErr = mem_err_reg;

endmodule
